// File: rtl/matrix_loader.sv
// Streams GF(M) matrix elements in row-major order, packs N per word, writes the
// words to the systemizer memory, then launches the systemizer and reports its result.
module matrix_loader #(
  parameter int N = 4,
  parameter int M = 3,
  parameter int L = 16,
  parameter int K = 24,
  localparam int E = $clog2(M),
  localparam int W = L * K / N,
  localparam int A = $clog2(W)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic             in_valid,
  input  logic [E-1:0]     in_data,
  output logic             in_ready,
  output logic             sys_wr_en,
  output logic [A-1:0]     sys_wr_addr,
  output logic [N*E-1:0]   sys_data_in,
  output logic             sys_start,
  input  logic             sys_done,
  input  logic             sys_fail,
  output logic             busy,
  output logic             done,
  output logic             fail
);

  localparam int LW = (N > 1) ? $clog2(N) : 1;

  typedef enum logic [2:0] {IDLE, LOAD, FLUSH, START, WAIT, FIN} state_t;

  state_t           state_q, state_d;
  logic [LW-1:0]    lane_q, lane_d;
  logic [A-1:0]     word_q, word_d;
  logic [A-1:0]     addr_q, addr_d;
  logic [N*E-1:0]   pack_q, pack_d;
  logic [N*E-1:0]   data_q, data_d;
  logic             wr_q, wr_d;
  logic             fail_q, fail_d;
  logic             accept;
  logic [N*E-1:0]   pack_ins;

  always_comb begin
    state_d  = state_q;
    lane_d   = lane_q;
    word_d   = word_q;
    addr_d   = addr_q;
    pack_d   = pack_q;
    data_d   = data_q;
    fail_d   = fail_q;
    wr_d     = 1'b0;
    accept   = (state_q == LOAD) && in_valid;
    pack_ins = pack_q;
    pack_ins[lane_q*E +: E] = in_data;

    case (state_q)
      IDLE: begin
        if (load) begin
          lane_d  = '0;
          word_d  = '0;
          fail_d  = 1'b0;
          state_d = LOAD;
        end
      end
      LOAD: begin
        if (accept) begin
          pack_d = pack_ins;
          if (lane_q == LW'(N - 1)) begin
            // Word complete: the registered strobe shows up the following cycle.
            lane_d = '0;
            wr_d   = 1'b1;
            addr_d = word_q;
            data_d = pack_ins;
            word_d = word_q + 1'b1;
            if (word_q == A'(W - 1)) state_d = FLUSH;
          end else begin
            lane_d = lane_q + 1'b1;
          end
        end
      end
      FLUSH: state_d = START;
      START: state_d = WAIT;
      WAIT: begin
        if (sys_done) begin
          fail_d  = sys_fail;
          state_d = FIN;
        end
      end
      FIN:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      lane_q  <= '0;
      word_q  <= '0;
      addr_q  <= '0;
      pack_q  <= '0;
      data_q  <= '0;
      wr_q    <= 1'b0;
      fail_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      lane_q  <= lane_d;
      word_q  <= word_d;
      addr_q  <= addr_d;
      pack_q  <= pack_d;
      data_q  <= data_d;
      wr_q    <= wr_d;
      fail_q  <= fail_d;
    end
  end

  assign in_ready    = (state_q == LOAD);
  assign sys_start   = (state_q == START);
  assign busy        = (state_q != IDLE);
  assign done        = (state_q == FIN);
  assign sys_wr_en   = wr_q;
  assign sys_wr_addr = addr_q;
  assign sys_data_in = data_q;
  assign fail        = fail_q;

endmodule

// File: tb/tb_matrix_loader.sv
// Directed bench for matrix_loader: a vector table for packing and gap handling,
// then full-matrix runs, completion/fail handling, ignored loads and reset abort.
module tb_matrix_loader;

  logic       clk = 1'b0;
  logic       rst;
  logic       load;
  logic       in_valid;
  logic [1:0] in_data;
  logic       in_ready;
  logic       sys_wr_en;
  logic [6:0] sys_wr_addr;
  logic [7:0] sys_data_in;
  logic       sys_start;
  logic       sys_done;
  logic       sys_fail;
  logic       busy;
  logic       done;
  logic       fail;

  int checks = 0;
  int errors = 0;
  bit mon_en = 1'b0;
  int mon_wr = 0;
  int mon_start = 0;

  matrix_loader #(.N(4), .M(3), .L(16), .K(24)) dut (
    .clk(clk), .rst(rst), .load(load), .in_valid(in_valid), .in_data(in_data),
    .in_ready(in_ready), .sys_wr_en(sys_wr_en), .sys_wr_addr(sys_wr_addr),
    .sys_data_in(sys_data_in), .sys_start(sys_start), .sys_done(sys_done),
    .sys_fail(sys_fail), .busy(busy), .done(done), .fail(fail)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       ld;
    logic       vld;
    logic [1:0] d;
    logic       rdy;
    logic       wr;
    logic [6:0] addr;
    logic [7:0] data;
    logic       start;
    logic       bsy;
  } vec_t;

  vec_t vecs[$];

  task automatic add_vec(input logic ld, input logic vld, input logic [1:0] d,
                         input logic rdy, input logic wr, input logic [6:0] addr,
                         input logic [7:0] data, input logic start, input logic bsy);
    vec_t v;
    v.ld = ld; v.vld = vld; v.d = d; v.rdy = rdy; v.wr = wr;
    v.addr = addr; v.data = data; v.start = start; v.bsy = bsy;
    vecs.push_back(v);
  endtask

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got 'h%0h, expected 'h%0h", name, act, exp);
    end
  endtask

  function automatic logic [1:0] elem(input int i);
    int v;
    v = (i * 5 + i / 7) % 3;
    return v[1:0];
  endfunction

  function automatic logic [7:0] exp_word(input int w);
    logic [7:0] r;
    r = '0;
    for (int k = 0; k < 4; k++) r[k*2 +: 2] = elem(4 * w + k);
    return r;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
    if (mon_en) begin
      chk("wr_start_overlap", int'(sys_wr_en & sys_start), 0);
      if (sys_wr_en) begin
        chk($sformatf("wr_addr[%0d]", mon_wr), int'(sys_wr_addr), mon_wr);
        chk($sformatf("wr_data[%0d]", mon_wr), int'(sys_data_in), int'(exp_word(mon_wr)));
        mon_wr++;
      end
      if (sys_start) mon_start++;
    end
  endtask

  task automatic start_load();
    load = 1'b1;
    step();
    load = 1'b0;
    mon_wr = 0;
    mon_start = 0;
    chk("load_ready", int'(in_ready), 1);
    chk("load_fail_clear", int'(fail), 0);
  endtask

  task automatic run_stream(input int n, input bit toggle);
    for (int i = 0; i < n; i++) begin
      in_valid = 1'b1;
      in_data  = elem(i);
      step();
      if (i == 383) chk("rdy_after_last", int'(in_ready), 0);
      if (toggle) begin
        in_valid = 1'b0;
        in_data  = 2'd3;
        load     = (i == 200);
        step();
        load     = 1'b0;
      end
    end
    in_valid = 1'b0;
  endtask

  task automatic finish_run(input logic f);
    for (int c = 0; c < 4 && mon_start == 0; c++) step();
    chk("write_count", mon_wr, 96);
    chk("start_count", mon_start, 1);
    step();
    chk("wait_busy", int'(busy), 1);
    load = 1'b1;
    step();
    load = 1'b0;
    step();
    chk("wait_load_ignored_busy", int'(busy), 1);
    chk("wait_no_done", int'(done), 0);
    chk("wait_no_extra_start", mon_start, 1);
    sys_done = 1'b1;
    sys_fail = f;
    step();
    sys_done = 1'b0;
    sys_fail = 1'b0;
    chk("done_pulse", int'(done), 1);
    chk("done_fail", int'(fail), int'(f));
    step();
    chk("done_low", int'(done), 0);
    chk("idle_busy", int'(busy), 0);
    chk("fail_hold", int'(fail), int'(f));
  endtask

  initial begin
    rst = 1'b1; load = 1'b0; in_valid = 1'b0; in_data = '0;
    sys_done = 1'b0; sys_fail = 1'b0;

    // ld vld d | rdy wr addr data start busy
    add_vec(1, 0, 0, 1, 0, 0, 8'h00, 0, 1);
    add_vec(0, 1, 1, 1, 0, 0, 8'h00, 0, 1);
    add_vec(0, 1, 2, 1, 0, 0, 8'h00, 0, 1);
    add_vec(0, 1, 0, 1, 0, 0, 8'h00, 0, 1);
    add_vec(0, 1, 1, 1, 1, 0, 8'h49, 0, 1);
    add_vec(0, 0, 0, 1, 0, 0, 8'h49, 0, 1);
    add_vec(1, 1, 3, 1, 0, 0, 8'h49, 0, 1);
    add_vec(0, 1, 1, 1, 0, 0, 8'h49, 0, 1);
    add_vec(0, 0, 2, 1, 0, 0, 8'h49, 0, 1);
    add_vec(0, 1, 2, 1, 0, 0, 8'h49, 0, 1);
    add_vec(0, 1, 3, 1, 1, 1, 8'hE7, 0, 1);
    add_vec(0, 0, 0, 1, 0, 1, 8'hE7, 0, 1);

    repeat (3) @(posedge clk);
    #1;
    chk("rst_ready", int'(in_ready), 0);
    chk("rst_wr_en", int'(sys_wr_en), 0);
    chk("rst_addr", int'(sys_wr_addr), 0);
    chk("rst_data", int'(sys_data_in), 0);
    chk("rst_start", int'(sys_start), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_done", int'(done), 0);
    chk("rst_fail", int'(fail), 0);
    rst = 1'b0;
    step();

    foreach (vecs[i]) begin
      load = vecs[i].ld; in_valid = vecs[i].vld; in_data = vecs[i].d;
      step();
      chk($sformatf("v%0d_ready", i), int'(in_ready), int'(vecs[i].rdy));
      chk($sformatf("v%0d_wr_en", i), int'(sys_wr_en), int'(vecs[i].wr));
      chk($sformatf("v%0d_addr", i), int'(sys_wr_addr), int'(vecs[i].addr));
      chk($sformatf("v%0d_data", i), int'(sys_data_in), int'(vecs[i].data));
      chk($sformatf("v%0d_start", i), int'(sys_start), int'(vecs[i].start));
      chk($sformatf("v%0d_busy", i), int'(busy), int'(vecs[i].bsy));
    end
    load = 1'b0; in_valid = 1'b0;

    rst = 1'b1;
    step();
    rst = 1'b0;
    step();
    mon_en = 1'b1;

    sys_done = 1'b1; sys_fail = 1'b1;
    step();
    sys_done = 1'b0; sys_fail = 1'b0;
    chk("idle_sys_done_done", int'(done), 0);
    chk("idle_sys_done_busy", int'(busy), 0);
    chk("idle_sys_done_fail", int'(fail), 0);

    start_load();
    run_stream(384, 1'b1);
    finish_run(1'b0);

    start_load();
    run_stream(384, 1'b0);
    finish_run(1'b1);
    repeat (3) step();
    chk("fail_sticky", int'(fail), 1);

    start_load();
    run_stream(150, 1'b0);
    chk("abort_writes_before", mon_wr, 37);
    rst = 1'b1;
    #1;
    chk("abort_ready", int'(in_ready), 0);
    chk("abort_wr_en", int'(sys_wr_en), 0);
    chk("abort_addr", int'(sys_wr_addr), 0);
    chk("abort_data", int'(sys_data_in), 0);
    chk("abort_busy", int'(busy), 0);
    chk("abort_fail", int'(fail), 0);
    step();
    step();
    rst = 1'b0;
    step();
    step();
    chk("abort_no_write", mon_wr, 37);
    chk("abort_no_start", mon_start, 0);
    chk("abort_idle", int'(busy), 0);

    start_load();
    run_stream(4, 1'b0);
    chk("restart_write_count", mon_wr, 1);
    chk("restart_addr", int'(sys_wr_addr), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/matrix_loader.md
MATRIX_LOADER -- requirements
Module: matrix_loader

Interface
REQ-001 Parameter N, default 4: GF(M) elements per memory word; equals the systemizer's N.
REQ-002 Parameter M, default 3: field size; element width E = CLOG2(M).
REQ-003 Parameter L, default 16; parameter K, default 24: matrix rows and columns; word count W = L*K/N, address width A = CLOG2(L*K/N).
REQ-004 clk  in  1: single clock; all state changes on its rising edge.
REQ-005 rst  in  1: reset, asynchronous, active-high.
REQ-006 load  in  1: one-cycle request to begin loading a matrix.
REQ-007 in_valid  in  1: in_data holds a valid element.
REQ-008 in_data  in  E: one matrix element, row-major order.
REQ-009 in_ready  out  1: loader accepts an element this cycle.
REQ-010 sys_wr_en  out  1: write strobe to the systemizer.
REQ-011 sys_wr_addr  out  A: systemizer word address.
REQ-012 sys_data_in  out  N*E: packed word to the systemizer.
REQ-013 sys_start  out  1: one-cycle start pulse to the systemizer.
REQ-014 sys_done  in  1: systemizer completion pulse.
REQ-015 sys_fail  in  1: systemizer failure flag, valid while sys_done=1.
REQ-016 busy  out  1: high in any state other than IDLE.
REQ-017 done  out  1: one-cycle pulse when the systemizer run completes.
REQ-018 fail  out  1: result flag; captured at completion, held until the next accepted load.

Function
REQ-019 The FSM states SHALL be IDLE, LOAD, FLUSH, START, WAIT and FIN.
REQ-020 In IDLE, load=1 SHALL clear the lane counter, word counter and fail, and enter LOAD; load in any other state SHALL be ignored.
REQ-021 in_ready SHALL be 1 exactly when the state is LOAD; an element is accepted when in_valid and in_ready are both 1.
REQ-022 The k-th accepted element of a word (k = 0..N-1) SHALL occupy bits [k*E +: E] of the packed word.
REQ-023 The cycle after the N-th element of a word is accepted, the block SHALL drive sys_wr_en=1 for exactly one cycle, with the word-counter value on sys_wr_addr and the packed word on sys_data_in. The word counter SHALL then increment.
REQ-024 Words SHALL be written at addresses 0..W-1 in order, with no gaps or repeats.
REQ-025 Back-to-back accepts SHALL sustain one element per cycle with no stall; in_valid=0 gaps SHALL only delay the process and SHALL NOT corrupt packing.
REQ-026 Acceptance of element N*W-1 SHALL move the FSM from LOAD to FLUSH; FLUSH carries the write of word W-1.
REQ-027 FLUSH SHALL go to START after one cycle; START SHALL assert sys_start for exactly one cycle and then go to WAIT.
REQ-028 In WAIT, sys_done=1 SHALL capture sys_fail into fail and move to FIN; sys_done outside WAIT SHALL be ignored.
REQ-029 FIN SHALL assert done for one cycle and then return to IDLE. Latency from sys_done to done is one cycle.
REQ-030 sys_wr_en and sys_start SHALL never be high in the same cycle.
REQ-031 When not strobed, sys_wr_addr and sys_data_in SHALL hold their last written values.

Reset
REQ-032 While rst=1, the state SHALL be IDLE and all counters and the pack register SHALL be 0.
REQ-033 While rst=1, in_ready, sys_wr_en, sys_start, busy, done and fail SHALL be 0, and sys_wr_addr and sys_data_in SHALL be 0.
REQ-034 Reset asserted mid-load or mid-WAIT SHALL abort the operation immediately; no further write or start SHALL be issued until a new load.

Verification (N=4, M=3, E=2, L=16, K=24, W=96)
REQ-035 Reset, then load; first elements 1,2,0,1 streamed continuously -> one cycle after the 4th accept: sys_wr_en=1, sys_wr_addr=0, sys_data_in=8'h49.
REQ-036 Full 384-element stream with in_valid toggling every other cycle -> exactly 96 writes at addresses 0..95 in order, then FLUSH, then a single sys_start pulse; in_ready=0 after the 384th accept.
REQ-037 In WAIT, drive sys_done=1 with sys_fail=0 -> done=1 the next cycle, fail=0, busy=0 the cycle after.
REQ-038 Repeat the run with sys_fail=1 at sys_done -> done pulse with fail=1; fail stays 1 until the next load, which clears it.
REQ-039 load pulses during LOAD and during WAIT -> no effect: counters continue and no extra sys_start is issued.
REQ-040 Assert rst after 150 accepted elements -> all outputs 0 immediately; a subsequent load restarts writes at address 0.
